// File: rtl/debounce_arbiter.sv
// debounce_arbiter: debounces N raw buttons using one shared settle timer granted round-robin
module debounce_arbiter #(
  parameter int N_BUTTONS = 4,
  parameter int IDX_W = 2,
  parameter int SETTLE_CYCLES = 30000000,
  parameter int CNT_W = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] debounced,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic busy,
  output logic [IDX_W-1:0] active_idx
);
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [N_BUTTONS-1:0] s1, sync, m;
  logic [IDX_W-1:0] rr_ptr, idx, pick, nxt;
  logic [CNT_W-1:0] timer;
  logic target, found, bounce;
  assign m = sync ^ debounced;
  assign nxt = IDX_W'((int'(idx) + 1) % N_BUTTONS);
  assign bounce = sync[idx] != target;
  assign busy = state != IDLE;
  assign active_idx = idx;
  // first mismatching button at or after rr_ptr, wrapping
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (!found && m[(int'(rr_ptr) + i) % N_BUTTONS]) begin
        found = 1'b1;
        pick = IDX_W'((int'(rr_ptr) + i) % N_BUTTONS);
      end
    end
  end
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (found ? SETTLE : IDLE) :
              state == SETTLE ? (bounce ? IDLE : timer == LAST ? COMMIT : SETTLE) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      s1 <= '0;
      sync <= '0;
      rr_ptr <= '0;
      idx <= '0;
      target <= 1'b0;
      timer <= '0;
      debounced <= '0;
      press <= '0;
      release_pulse <= '0;
    end else begin
      state <= state_n;
      s1 <= btn_raw;
      sync <= s1;
      press <= '0;
      release_pulse <= '0;
      if (state == IDLE && found) begin
        idx <= pick;
        target <= sync[pick];
        timer <= '0;
      end
      if (state == SETTLE) begin
        if (bounce) rr_ptr <= nxt;
        else if (timer != LAST) timer <= timer + 1'b1;
      end
      if (state == COMMIT) begin
        debounced[idx] <= target;
        press[idx] <= target;
        release_pulse[idx] <= ~target;
        rr_ptr <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_debounce_arbiter.sv
// tb_debounce_arbiter: directed table-driven checks of debounce_arbiter with 4 buttons, 4 settle cycles
module tb_debounce_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] btn_raw = 4'b1111;
  logic [3:0] debounced, press, release_pulse, pulses;
  logic busy;
  logic [1:0] active_idx;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic [3:0] raw;
    int n;
    logic [3:0] deb, prs, rel;
    logic bsy;
    logic [1:0] idx;
  } vec_t;
  vec_t v[$];

  debounce_arbiter #(.N_BUTTONS(4), .IDX_W(2), .SETTLE_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .debounced(debounced),
    .press(press), .release_pulse(release_pulse), .busy(busy), .active_idx(active_idx)
  );

  always #5 clock = ~clock;
  assign pulses = press | release_pulse;

  task automatic add(input logic rst, input logic [3:0] raw, input int n, input logic [3:0] deb,
                     input logic [3:0] prs, input logic [3:0] rel, input logic bsy, input logic [1:0] idx);
    vec_t e;
    e.rst = rst; e.raw = raw; e.n = n; e.deb = deb; e.prs = prs; e.rel = rel; e.bsy = bsy; e.idx = idx;
    v.push_back(e);
  endtask

  task automatic chk(input string name, input int i, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %b expected %b", name, i, act, exp);
    end
  endtask

  // press and release pulses must never overlap across buttons
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if ($countones(pulses) > 1) begin
        errors++;
        $display("FAIL pulse_onehot: got %b expected at most one bit", pulses);
      end
    end
  end

  initial begin
    int k;
    add(1, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 7, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(0, 4'b1111, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0001, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b1111, 5, 4'b0011, 4'b0010, 4'b0000, 0, 1);
    add(0, 4'b1111, 6, 4'b0111, 4'b0100, 4'b0000, 0, 2);
    add(0, 4'b1111, 6, 4'b1111, 4'b1000, 4'b0000, 0, 3);
    add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 0, 3);
    add(0, 4'b1011, 7, 4'b1111, 4'b0000, 4'b0000, 1, 2);
    add(0, 4'b1011, 1, 4'b1011, 4'b0000, 4'b0100, 0, 2);
    add(0, 4'b1111, 8, 4'b1111, 4'b0100, 4'b0000, 0, 2);
    add(0, 4'b1101, 2, 4'b1111, 4'b0000, 4'b0000, 0, 2);
    add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 4'b1111, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b1111, 5, 4'b1111, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b1101, 8, 4'b1101, 4'b0000, 4'b0010, 0, 1);
    add(0, 4'b0100, 8, 4'b0101, 4'b0000, 4'b1000, 0, 3);
    add(0, 4'b0100, 6, 4'b0100, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1101, 8, 4'b1100, 4'b1000, 4'b0000, 0, 3);
    add(0, 4'b1101, 6, 4'b1101, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0101, 8, 4'b0101, 4'b0000, 4'b1000, 0, 3);
    add(0, 4'b1100, 8, 4'b0100, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1100, 1, 4'b0100, 4'b0000, 4'b0000, 1, 3);
    add(0, 4'b1100, 5, 4'b1100, 4'b1000, 4'b0000, 0, 3);
    add(0, 4'b1110, 5, 4'b1100, 4'b0000, 4'b0000, 1, 1);
    add(1, 4'b1110, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1110, 7, 4'b0000, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b1110, 1, 4'b0010, 4'b0010, 4'b0000, 0, 1);
    foreach (v[i]) begin
      @(negedge clock);
      reset = v[i].rst;
      btn_raw = v[i].raw;
      repeat (v[i].n) @(posedge clock);
      #1;
      chk("debounced", i, debounced, v[i].deb);
      chk("press", i, press, v[i].prs);
      chk("release", i, release_pulse, v[i].rel);
      chk("busy", i, {3'b000, busy}, {3'b000, v[i].bsy});
      chk("active_idx", i, {2'b00, active_idx}, {2'b00, v[i].idx});
    end
    // button 2 is still pending and must be granted right after the idle gap
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(posedge clock);
      #1;
      if (press[2]) k = c;
    end
    chk("press2_latency", 0, 4'(k), 4'd6);
    chk("press2_deb", 0, debounced, 4'b0110);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
